big_alu_seq: RTL and testbench

BIG_ALU_SEQ -- requirements
Module: big_alu_seq

---
 rtl/big_alu_seq.sv | 145 ++++++++++++++
 tb/tb_big_alu_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/big_alu_seq.sv
// Sequencer for the big ALU datapath: latches a request, steers the add/sub/mul
// datapath controls, captures the 64-bit result and reports done/error.
module big_alu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [27:0] a,
  input  logic [27:0] b,
  input  logic        alu_finished,
  input  logic [63:0] alu_result,
  output logic        alu_isSum,
  output logic        alu_sum_sub,
  output logic        alu_reset,
  output logic        alu_muxDataRegValor2,
  output logic [27:0] alu_valor1,
  output logic [27:0] alu_valor2,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        error
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StExec = 3'd2;
  localparam logic [2:0] StRun  = 3'd3;
  localparam logic [2:0] StCapt = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  localparam logic [1:0] OpAdd     = 2'b00;
  localparam logic [1:0] OpSub     = 2'b01;
  localparam logic [1:0] OpMul     = 2'b10;
  localparam logic [1:0] OpIllegal = 2'b11;

  localparam logic [4:0] LastRunCnt = 5'd28;

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [27:0] a_q, a_d, b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;
  logic        error_q, error_d;
  logic        bypass;
  logic [63:0] bypass_res;

  // Bypass and illegal requests pass through CAPT so their result lands like a normal capture.
  assign bypass = (op_q == OpIllegal) || (b_q == 28'd0);

  always_comb begin
    bypass_res = 64'd0;
    if (op_q == OpAdd) begin
      bypass_res = {36'd0, a_q};
    end else if (op_q == OpSub) begin
      bypass_res = 64'd0 - {36'd0, a_q};
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = error_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          op_d = op;
          a_d  = a;
          b_d  = b;
          state_d = ((op == OpIllegal) || (b == 28'd0)) ? StCapt : StLoad;
        end
      end
      StLoad: begin
        cnt_d   = 5'd0;
        state_d = (op_q == OpMul) ? StRun : StExec;
      end
      StExec: state_d = StCapt;
      StRun: begin
        cnt_d = cnt_q + 5'd1;
        if (alu_finished) begin
          state_d = StCapt;
        end else if (cnt_q == LastRunCnt) begin
          // Multiplier never signalled completion: report a timeout.
          result_d = alu_result;
          error_d  = 1'b1;
          state_d  = StDone;
        end
      end
      StCapt: begin
        if (op_q == OpIllegal) begin
          result_d = 64'd0;
          error_d  = 1'b1;
        end else if (b_q == 28'd0) begin
          result_d = bypass_res;
          error_d  = 1'b0;
        end else begin
          result_d = alu_result;
          error_d  = 1'b0;
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      a_q      <= 28'd0;
      b_q      <= 28'd0;
      cnt_q    <= 5'd0;
      result_q <= 64'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  logic active;
  assign active = !bypass && ((state_q == StLoad) || (state_q == StExec) ||
                              (state_q == StRun)  || (state_q == StCapt));

  assign alu_isSum            = active && !op_q[1];
  assign alu_sum_sub          = active && !op_q[1] && op_q[0];
  assign alu_reset            = (state_q == StLoad);
  assign alu_muxDataRegValor2 = (state_q == StRun);
  assign alu_valor1           = a_q;
  assign alu_valor2           = b_q;
  assign busy                 = (state_q != StIdle);
  assign done                 = (state_q == StDone);
  assign result               = result_q;
  assign error                = error_q;

endmodule

// File: tb/tb_big_alu_seq.sv
// Directed bench for big_alu_seq: stimulus pushes expected completions into a queue,
// a negedge monitor pops and checks them whenever done is seen.
module tb_big_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [27:0] a, b;
  logic        alu_finished;
  logic [63:0] alu_result;
  logic        alu_isSum, alu_sum_sub, alu_reset, alu_muxDataRegValor2;
  logic [27:0] alu_valor1, alu_valor2;
  logic        busy, done, error;
  logic [63:0] result;

  big_alu_seq dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .op                   (op),
    .a                    (a),
    .b                    (b),
    .alu_finished         (alu_finished),
    .alu_result           (alu_result),
    .alu_isSum            (alu_isSum),
    .alu_sum_sub          (alu_sum_sub),
    .alu_reset            (alu_reset),
    .alu_muxDataRegValor2 (alu_muxDataRegValor2),
    .alu_valor1           (alu_valor1),
    .alu_valor2           (alu_valor2),
    .busy                 (busy),
    .done                 (done),
    .result               (result),
    .error                (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Scoreboard monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("error", {63'd0, error}, {63'd0, e.err});
        chk("latency", 64'(cyc - acc_cyc + 1), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [27:0] va, input logic [27:0] vb,
                       input bit push, input logic [63:0] res, input logic err,
                       input int lat);
    exp_t e;
    @(negedge clk);
    op = o; a = va; b = vb; start = 1'b1;
    if (push) begin
      e.res = res; e.err = err; e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", {63'd0, busy}, 64'd0);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    alu_finished = 1'b0; alu_result = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_ctrl", {60'd0, alu_isSum, alu_sum_sub, alu_reset, alu_muxDataRegValor2}, 64'd0);

    // add 5+3, plus a start pulsed while busy that must be ignored
    issue(2'b00, 28'd5, 28'd3, 1'b1, 64'd8, 1'b0, 4);
    @(negedge clk);
    chk("add_load_rst", {63'd0, alu_reset}, 64'd1);
    chk("add_load_mux", {63'd0, alu_muxDataRegValor2}, 64'd0);
    chk("add_isSum", {63'd0, alu_isSum}, 64'd1);
    chk("add_sum_sub", {63'd0, alu_sum_sub}, 64'd0);
    chk("add_valor1", {36'd0, alu_valor1}, 64'd5);
    @(negedge clk);
    alu_result = 64'd8;
    chk("add_exec_rst", {63'd0, alu_reset}, 64'd0);
    start = 1'b1; a = 28'd99; b = 28'd77; op = 2'b10;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_v1", {36'd0, alu_valor1}, 64'd5);
    chk("busy_start_v2", {36'd0, alu_valor2}, 64'd3);
    wait_idle();

    // sub 10-4
    issue(2'b01, 28'd10, 28'd4, 1'b1, 64'd6, 1'b0, 4);
    @(negedge clk);
    chk("sub_sum_sub", {63'd0, alu_sum_sub}, 64'd1);
    chk("sub_load_rst", {63'd0, alu_reset}, 64'd1);
    @(negedge clk);
    alu_result = 64'd6;
    wait_idle();

    // mul 7*6, finished after 3 RUN cycles
    issue(2'b10, 28'd7, 28'd6, 1'b1, 64'd42, 1'b0, 6);
    @(negedge clk);
    chk("mul_load_rst", {63'd0, alu_reset}, 64'd1);
    chk("mul_load_mux", {63'd0, alu_muxDataRegValor2}, 64'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("mul_run_mux", {63'd0, alu_muxDataRegValor2}, 64'd1);
      chk("mul_run_ctrl", {61'd0, alu_isSum, alu_sum_sub, alu_reset}, 64'd0);
      if (i == 3) begin
        alu_finished = 1'b1;
        alu_result   = 64'd42;
      end
    end
    @(negedge clk);
    alu_finished = 1'b0;
    wait_idle();

    // b==0 bypasses and illegal op
    alu_result = 64'hDEAD;
    issue(2'b00, 28'd9, 28'd0, 1'b1, 64'd9, 1'b0, 2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("byp_no_alu_reset", {63'd0, alu_reset}, 64'd0);
    end
    wait_idle();
    issue(2'b01, 28'd1, 28'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2);
    wait_idle();
    issue(2'b11, 28'd3, 28'd4, 1'b1, 64'd0, 1'b1, 2);
    wait_idle();

    // mul timeout: LOAD, 29 RUN cycles, then DONE
    alu_result = 64'h1234_5678;
    issue(2'b10, 28'd2, 28'd3, 1'b1, 64'h1234_5678, 1'b1, 31);
    wait_idle();

    // reset in RUN aborts without done
    issue(2'b10, 28'd4, 28'd5, 1'b0, 64'd0, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_mux", {63'd0, alu_muxDataRegValor2}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_busy", {63'd0, busy}, 64'd0);
    chk("midrun_done", {63'd0, done}, 64'd0);
    chk("midrun_valor1", {36'd0, alu_valor1}, 64'd0);
    chk("midrun_result", result, 64'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
